// File: rtl/updown_counter8.sv
// Free-running synchronous up/down counter with terminal-value flags and a
// registered one-cycle wrap pulse. rst_n is active-high despite its name.
module updown_counter8 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             down,
    output logic [WIDTH-1:0] count,
    output logic             at_zero,
    output logic             at_max,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (!down) begin
            count <= count + ONE;
            wrap  <= (count == '1);
        end else begin
            count <= count - ONE;
            wrap  <= (count == '0);
        end
    end

    always_comb begin
        at_zero = (count == '0);
        at_max  = (count == '1);
    end

endmodule

// File: tb/tb_updown_counter8.sv
// Scoreboarded bench for updown_counter8: directed scenarios then random
// direction/reset traffic, checked against an arithmetic reference model.
module tb_updown_counter8;

    localparam int unsigned W   = 8;
    localparam longint      MOD = longint'(1) << W;

    typedef struct {
        logic [W-1:0] cnt;
        logic         z;
        logic         mx;
        logic         wr;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         down;
    logic [W-1:0] count;
    logic         at_zero;
    logic         at_max;
    logic         wrap;

    exp_t exp_q[$];
    int   tests;
    int   fails;
    bit   stim_done;

    longint m_cnt;
    logic   m_wrap;

    updown_counter8 #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .down   (down),
        .count  (count),
        .at_zero(at_zero),
        .at_max (at_max),
        .wrap   (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge of stimulus; the model predicts the state just after it.
    task automatic step(input logic r, input logic d);
        exp_t   e;
        longint nxt;
        @(negedge clk);
        rst_n = r;
        down  = d;
        if (r) begin
            m_cnt  = 0;
            m_wrap = 1'b0;
        end else begin
            nxt    = d ? m_cnt - 1 : m_cnt + 1;
            m_wrap = (nxt < 0) || (nxt >= MOD);
            m_cnt  = (nxt + MOD) % MOD;
        end
        e.cnt = m_cnt[W-1:0];
        e.z   = (m_cnt == 0);
        e.mx  = (m_cnt == MOD - 1);
        e.wr  = m_wrap;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        down      = 1'b0;
        tests     = 0;
        fails     = 0;
        stim_done = 1'b0;
        m_cnt     = 0;
        m_wrap    = 1'b0;

        // reset, count up 5, down 3, up 2
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0);

        // underflow from reset
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        // full overflow lap
        step(1'b1, 1'b0);
        repeat (257) step(1'b0, 1'b0);

        // mid-run reset at 0x37
        step(1'b1, 1'b0);
        repeat (8'h37) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);

        // reset overriding a pending wrap: at 255 counting up
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // random traffic with direction runs and occasional resets
        begin
            logic d;
            d = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 7) == 0) d = ~d;
                step($urandom_range(0, 99) == 0, d);
            end
        end

        @(negedge clk);
        stim_done = 1'b1;
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count",   32'(count),   32'(e.cnt));
                chk("at_zero", 32'(at_zero), 32'(e.z));
                chk("at_max",  32'(at_max),  32'(e.mx));
                chk("wrap",    32'(wrap),    32'(e.wr));
            end
            if (stim_done && exp_q.size() == 0) break;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL timeout: got no completion, expected end within 1000000 time units");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/updown_counter8.md
Name: updown_counter8

Overview:
- Free-running synchronous binary up/down counter, default 8 bits wide.
- Counts up or down by one on every clock edge, as selected by a direction input.
- Wraps modulo 2^WIDTH. Provides terminal-value status flags and a one-cycle wrap pulse.
- Leaf block for cycle counting, timers and address generation; used as the reference counter in pre/post-synthesis flow checks.

Parameters:
- WIDTH, 8, counter width in bits. Legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-high. Despite the name, rst_n=1 resets the block; sampled only on the rising edge of clk.
- down  input  1  direction select: 0 = count up, 1 = count down. Sampled on the rising edge of clk.
- count  output  WIDTH  current count value, driven directly from a register.
- at_zero  output  1  combinational; 1 when count == 0.
- at_max  output  1  combinational; 1 when count == 2^WIDTH-1 (255 at default).
- wrap  output  1  registered; 1 for exactly one cycle after an update that wrapped (up 255->0 or down 0->255).

Behaviour:
- Single clock domain. No asynchronous logic. No enable input: the counter updates every cycle when not in reset.
- Per rising edge, in priority order:
  - rst_n==1: count<=0, wrap<=0.
  - else down==0: count<=count+1 mod 2^WIDTH; wrap<=(count==all-ones).
  - else down==1: count<=count-1 mod 2^WIDTH; wrap<=(count==0).
- Reset values: count=0, wrap=0. at_zero=1 and at_max=0 follow combinationally.
- Power-up state before the first reset is unspecified (X in simulation). Benches must apply reset before checking values.
- Latency: count reflects an input change one cycle later.
  - A down toggle is seen at the next rising edge and changes the step for that edge. No pipeline, no hysteresis.
- Reset mid-operation: takes effect at the next edge regardless of down or current value, and overrides any pending wrap.
  - Release: first increment/decrement occurs at the first edge where rst_n==0. That edge yields 1 (up) or 2^WIDTH-1 (down).
- Direction reversal: applies immediately with no skipped or repeated value.
  - Example: 3 up -> 4, then down -> 3.
- Wrap-around is modular with no saturation.
  - wrap asserts only on the cycle after the wrapping edge; never in reset.
- Arithmetic is unsigned, WIDTH bits; carries/borrows beyond WIDTH are discarded.
- down and rst_n must be synchronous to clk; no internal synchronizers.

Test Plan:
- Reset: hold rst_n=1 for 2 edges with down=0 -> count=0, at_zero=1, at_max=0, wrap=0 after the first edge.
- Count up: release reset, down=0 for 5 edges -> count 1,2,3,4,5 on successive edges; at_zero=0.
- Direction change: from count=5, set down=1 for 3 edges -> 4,3,2; set down=0 for 2 edges -> 3,4.
- Underflow: from reset, down=1 -> count=255, at_max=1, wrap=1 for one cycle; next edge -> 254, wrap=0.
- Overflow: count up from 0 for 256 edges -> reaches 255 (at_max=1), then 0 with wrap=1 for exactly one cycle, at_zero=1.
- Mid-run reset: at count=0x37 counting up, pulse rst_n=1 for 1 edge -> count=0 next edge, wrap=0; after release, counting resumes 1,2,…
